// File: rtl/ysyx_24100005_pkg.sv
// Shared constants for the ysyx_24100005 integer register file.
package ysyx_24100005_pkg;

    localparam int unsigned RF_ADDR_WIDTH = 5;
    localparam int unsigned RF_DATA_WIDTH = 32;

    // x0 is hardwired to zero and has no storage behind it.
    localparam int unsigned ZERO_REG_IDX = 0;

    // Every stored bit resets to this value; it is replicated to the entry width.
    localparam logic RF_RESET_BIT = 1'b0;

    function automatic logic [RF_DATA_WIDTH-1:0] rf_reset_val();
        return {RF_DATA_WIDTH{RF_RESET_BIT}};
    endfunction

endpackage

// File: rtl/ysyx_24100005_register_file_reg.sv
// Parameterized enabled register with synchronous active-low reset.
// One instance backs each non-zero register file entry.
module ysyx_24100005_reg
    import ysyx_24100005_pkg::*;
#(
    parameter int unsigned        WIDTH     = RF_DATA_WIDTH,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{RF_RESET_BIT}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Load new data only when this entry is selected for writing.
    always_comb begin
        data_d = data_q;
        if (wen) begin
            data_d = din;
        end
    end

    // Reset wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign dout = data_q;

endmodule

// File: rtl/ysyx_24100005_register_file.sv
// RV32 integer register file: two combinational read ports, one write port.
// Entry 0 reads as zero and ignores writes.
// Optional feature: define YSYX_24100005_RF_BYPASS_EN to forward the
// in-flight write data to a read port addressing the same register.
module ysyx_24100005_register_file
    import ysyx_24100005_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] rs1addr,
    input  logic [ADDR_WIDTH-1:0] rs2addr,
    output logic [DATA_WIDTH-1:0] rs1data,
    output logic [DATA_WIDTH-1:0] rs2data
);

    localparam int unsigned NUM_ENTRIES = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] entry_val [NUM_ENTRIES];

    assign entry_val[ZERO_REG_IDX] = '0;

    genvar gi;
    generate
        for (gi = ZERO_REG_IDX + 1; gi < NUM_ENTRIES; gi++) begin : g_entry
            logic entry_wen;
            assign entry_wen = wen && (waddr == ADDR_WIDTH'(gi));

            ysyx_24100005_reg #(
                .WIDTH     (DATA_WIDTH),
                .RESET_VAL ({DATA_WIDTH{RF_RESET_BIT}})
            ) u_reg (
                .clk  (clk),
                .rst  (rst),
                .wen  (entry_wen),
                .din  (wdata),
                .dout (entry_val[gi])
            );
        end
    endgenerate

`ifdef YSYX_24100005_RF_BYPASS_EN
    logic fwd_valid;
    assign fwd_valid = wen && rst && (waddr != ADDR_WIDTH'(ZERO_REG_IDX));
`endif

    // Read port 1: key-match mux over all entries, zero by default.
    always_comb begin
        rs1data = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (rs1addr == ADDR_WIDTH'(i)) begin
                rs1data = entry_val[i];
            end
        end
`ifdef YSYX_24100005_RF_BYPASS_EN
        if (fwd_valid && (rs1addr == waddr)) begin
            rs1data = wdata;
        end
`endif
    end

    // Read port 2: independent copy of the port 1 mux.
    always_comb begin
        rs2data = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (rs2addr == ADDR_WIDTH'(i)) begin
                rs2data = entry_val[i];
            end
        end
`ifdef YSYX_24100005_RF_BYPASS_EN
        if (fwd_valid && (rs2addr == waddr)) begin
            rs2data = wdata;
        end
`endif
    end

endmodule

// File: tb/tb_ysyx_24100005_register_file.sv
// Directed bench for ysyx_24100005_register_file (default 5x32 geometry).
module tb_ysyx_24100005_register_file;

    logic        clk;
    logic        rst;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  rs1addr;
    logic [4:0]  rs2addr;
    logic [31:0] rs1data;
    logic [31:0] rs2data;

    int n_tests;
    int n_fail;

    ysyx_24100005_register_file #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wen     (wen),
        .waddr   (waddr),
        .wdata   (wdata),
        .rs1addr (rs1addr),
        .rs2addr (rs2addr),
        .rs1data (rs1data),
        .rs2data (rs2data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        wen   = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        rs1addr = a1;
        rs2addr = a2;
        #1;
    endtask

    logic [31:0] exp_v;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        wen     = 1'b0;
        waddr   = '0;
        wdata   = '0;
        rs1addr = '0;
        rs2addr = '0;
        tick();
        tick();
        rst = 1'b1;

        rd(5'd1, 5'd31);
        check_eq("post_reset_x1", rs1data, 32'h0000_0000);
        check_eq("post_reset_x31", rs2data, 32'h0000_0000);

        // Reset clears a previously written entry, but only at the edge.
        wr(5'd5, 32'hDEAD_BEEF);
        rd(5'd5, 5'd5);
        check_eq("x5_written", rs1data, 32'hDEAD_BEEF);
        rst = 1'b0;
        #1;
        check_eq("reset_pending_old_value", rs1data, 32'hDEAD_BEEF);
        tick();
        check_eq("reset_low_outputs_follow_store", rs2data, 32'h0000_0000);
        rst = 1'b1;
        rd(5'd5, 5'd5);
        check_eq("reset_x5_rs1", rs1data, 32'h0000_0000);
        check_eq("reset_x5_rs2", rs2data, 32'h0000_0000);

        // Basic write/read on both ports, then wen=0 must not disturb it.
        wr(5'd3, 32'h1234_5678);
        rd(5'd3, 5'd3);
        check_eq("x3_rs1", rs1data, 32'h1234_5678);
        check_eq("x3_rs2", rs2data, 32'h1234_5678);
        wen   = 1'b0;
        waddr = 5'd3;
        wdata = 32'hFFFF_FFFF;
        tick();
        rd(5'd3, 5'd4);
        check_eq("x3_wen0_kept", rs1data, 32'h1234_5678);
        check_eq("x4_wen0_untouched", rs2data, 32'h0000_0000);

        // x0 ignores writes.
        wr(5'd0, 32'hAAAA_AAAA);
        rd(5'd0, 5'd0);
        check_eq("x0_rs1", rs1data, 32'h0000_0000);
        check_eq("x0_rs2", rs2data, 32'h0000_0000);

        // Full sweep: entry i holds (i<<24)|i.
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), (32'(i) << 24) | 32'(i));
        end
        for (int i = 1; i < 32; i++) begin
            rd(5'(i), 5'(32 - i));
            exp_v = (32'(i) << 24) | 32'(i);
            check_eq($sformatf("sweep_rs1_x%0d", i), rs1data, exp_v);
            exp_v = (32'(32 - i) << 24) | 32'(32 - i);
            check_eq($sformatf("sweep_rs2_x%0d", 32 - i), rs2data, exp_v);
        end
        rd(5'd31, 5'd0);
        check_eq("sweep_x31", rs1data, 32'h1F00_001F);
        check_eq("sweep_x0", rs2data, 32'h0000_0000);

        // Read-during-write on x7.
        wr(5'd7, 32'h1111_1111);
        wen     = 1'b1;
        waddr   = 5'd7;
        wdata   = 32'h2222_2222;
        rs1addr = 5'd7;
        rs2addr = 5'd7;
        #1;
`ifdef YSYX_24100005_RF_BYPASS_EN
        check_eq("rdw_before_edge_rs1", rs1data, 32'h2222_2222);
        check_eq("rdw_before_edge_rs2", rs2data, 32'h2222_2222);
`else
        check_eq("rdw_before_edge_rs1", rs1data, 32'h1111_1111);
        check_eq("rdw_before_edge_rs2", rs2data, 32'h1111_1111);
`endif
        tick();
        wen = 1'b0;
        #1;
        check_eq("rdw_after_edge", rs1data, 32'h2222_2222);

        // Reset beats a simultaneous write.
        rst   = 1'b0;
        wen   = 1'b1;
        waddr = 5'd9;
        wdata = 32'h0000_0055;
        tick();
        rst = 1'b1;
        wen = 1'b0;
        rd(5'd9, 5'd31);
        check_eq("reset_beats_write_x9", rs1data, 32'h0000_0000);
        check_eq("reset_clears_x31", rs2data, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
